// File: rtl/ctrl_mc.sv
// Multi-cycle control FSM for the SISC processor: sequences fetch/decode/execute/mem/writeback,
// short-circuits branches and NOOP, waits on data memory with a bounded timeout, and halts.
module ctrl_mc #(
    parameter int unsigned OP_W     = 4,
    parameter int unsigned MM_W     = 4,
    parameter int unsigned IMM_MM   = 8,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic [OP_W-1:0] opcode,
    input  logic [MM_W-1:0] mm,
    input  logic [MM_W-1:0] stat,
    input  logic            mem_ready,
    output logic            rf_we,
    output logic [1:0]      wb_sel,
    output logic            rb_sel,
    output logic            br_sel,
    output logic            pc_sel,
    output logic            pc_write,
    output logic            pc_rst,
    output logic            ir_load,
    output logic [1:0]      alu_op,
    output logic            mem_req,
    output logic            dm_we,
    output logic            halted,
    output logic            timeout,
    output logic            ill_op,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        StStart0    = 3'd0,
        StStart1    = 3'd1,
        StFetch     = 3'd2,
        StDecode    = 3'd3,
        StExecute   = 3'd4,
        StMem       = 3'd5,
        StWriteback = 3'd6,
        StHalt      = 3'd7
    } state_e;

    localparam logic [OP_W-1:0] OpNoop = OP_W'(0);
    localparam logic [OP_W-1:0] OpLod  = OP_W'(1);
    localparam logic [OP_W-1:0] OpStr  = OP_W'(2);
    localparam logic [OP_W-1:0] OpSwp  = OP_W'(3);
    localparam logic [OP_W-1:0] OpBra  = OP_W'(4);
    localparam logic [OP_W-1:0] OpBrr  = OP_W'(5);
    localparam logic [OP_W-1:0] OpBne  = OP_W'(6);
    localparam logic [OP_W-1:0] OpBnr  = OP_W'(7);
    localparam logic [OP_W-1:0] OpAlu  = OP_W'(8);
    localparam logic [OP_W-1:0] OpHlt  = OP_W'(15);

    localparam logic [MM_W-1:0]   ImmMm   = MM_W'(IMM_MM);
    localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

    localparam logic [1:0] AluReg  = 2'b00;
    localparam logic [1:0] AluAdd  = 2'b01;
    localparam logic [1:0] AluPass = 2'b10;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;

    logic       is_legal;
    logic       is_branch;
    logic       is_mem_op;
    logic       br_taken;
    logic [1:0] alu_exec;

    always_comb begin
        is_legal  = (opcode <= OpAlu) || (opcode == OpHlt);
        is_branch = (opcode == OpBra) || (opcode == OpBrr) ||
                    (opcode == OpBne) || (opcode == OpBnr);
        is_mem_op = (opcode == OpLod) || (opcode == OpStr);
        // BRA/BRR branch on any selected flag set, BNE/BNR on all selected flags clear
        if ((opcode == OpBra) || (opcode == OpBrr)) begin
            br_taken = |(stat & mm);
        end else begin
            br_taken = ~|(stat & mm);
        end
        alu_exec = (opcode == OpLod || opcode == OpStr) ? AluAdd :
                   (opcode == OpSwp)                    ? AluPass :
                   (mm == ImmMm)                        ? AluAdd : AluReg;
    end

    // Next-state, wait counter and sticky timeout
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StStart0: state_d = StStart1;
            StStart1: state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (opcode == OpHlt) begin
                    state_d = StHalt;
                end else if (opcode == OpNoop || is_branch || !is_legal) begin
                    state_d = StFetch;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: state_d = StMem;
            StMem: begin
                if (is_mem_op) begin
                    if (mem_ready) begin
                        wait_d  = '0;
                        state_d = (opcode == OpLod) ? StWriteback : StFetch;
                    end else if (wait_q >= MaxWait) begin
                        wait_d    = '0;
                        timeout_d = 1'b1;
                        state_d   = StHalt;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    state_d = StWriteback;
                end
            end
            StWriteback: state_d = StFetch;
            StHalt:      state_d = StHalt;
            default:     state_d = StStart0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q   <= StStart0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Datapath controls decoded from present state and IR fields
    always_comb begin
        rf_we    = 1'b0;
        wb_sel   = 2'd0;
        rb_sel   = 1'b0;
        br_sel   = 1'b0;
        pc_sel   = 1'b0;
        pc_write = 1'b0;
        pc_rst   = 1'b0;
        ir_load  = 1'b0;
        alu_op   = AluPass;
        mem_req  = 1'b0;
        dm_we    = 1'b0;
        halted   = 1'b0;
        ill_op   = 1'b0;
        unique case (state_q)
            StStart1: pc_rst = 1'b1;
            StFetch: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
            end
            StDecode: begin
                if (!is_legal) begin
                    ill_op = 1'b1;
                end else if (is_branch) begin
                    br_sel = (opcode == OpBra) || (opcode == OpBne);
                    if (br_taken) begin
                        pc_sel   = 1'b1;
                        pc_write = 1'b1;
                    end
                end
            end
            StExecute: begin
                if (is_mem_op || opcode == OpAlu || opcode == OpSwp) begin
                    alu_op = alu_exec;
                end
            end
            StMem: begin
                if (opcode == OpAlu) begin
                    alu_op = alu_exec;
                end else if (opcode == OpLod) begin
                    mem_req = 1'b1;
                    alu_op  = AluAdd;
                end else if (opcode == OpStr) begin
                    mem_req = 1'b1;
                    dm_we   = 1'b1;
                    alu_op  = AluAdd;
                end else if (opcode == OpSwp) begin
                    rf_we  = 1'b1;
                    wb_sel = 2'd2;
                    rb_sel = 1'b1;
                end
            end
            StWriteback: begin
                if (opcode == OpAlu) begin
                    rf_we  = 1'b1;
                    wb_sel = 2'd0;
                    rb_sel = 1'b1;
                    alu_op = alu_exec;
                end else if (opcode == OpLod) begin
                    rf_we  = 1'b1;
                    wb_sel = 2'd1;
                end else if (opcode == OpSwp) begin
                    rf_we  = 1'b1;
                    wb_sel = 2'd3;
                    rb_sel = 1'b1;
                end
            end
            StHalt:   halted = 1'b1;
            default:  ;
        endcase
    end

    assign timeout = timeout_q;
    assign state   = state_q;

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed bench for ctrl_mc: walks each instruction class through the FSM and compares every
// cycle's full output vector against hand-built expectations.
module tb_ctrl_mc;

    logic       clk = 1'b0;
    logic       rst_f = 1'b1;
    logic [3:0] opcode = '0;
    logic [3:0] mm = '0;
    logic [3:0] stat = '0;
    logic       mem_ready = 1'b0;

    logic       rf_we, rb_sel, br_sel, pc_sel, pc_write, pc_rst, ir_load;
    logic       mem_req, dm_we, halted, timeout, ill_op;
    logic [1:0] wb_sel, alu_op;
    logic [2:0] state;

    ctrl_mc #(
        .OP_W(4), .MM_W(4), .IMM_MM(8), .MAX_WAIT(15), .WAIT_W(8)
    ) dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
        .mem_ready(mem_ready), .rf_we(rf_we), .wb_sel(wb_sel), .rb_sel(rb_sel),
        .br_sel(br_sel), .pc_sel(pc_sel), .pc_write(pc_write), .pc_rst(pc_rst),
        .ir_load(ir_load), .alu_op(alu_op), .mem_req(mem_req), .dm_we(dm_we),
        .halted(halted), .timeout(timeout), .ill_op(ill_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] state;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       rb_sel;
        logic       br_sel;
        logic       pc_sel;
        logic       pc_write;
        logic       pc_rst;
        logic       ir_load;
        logic [1:0] alu_op;
        logic       mem_req;
        logic       dm_we;
        logic       halted;
        logic       timeout;
        logic       ill_op;
    } outs_t;

    outs_t obs;
    assign obs = {state, rf_we, wb_sel, rb_sel, br_sel, pc_sel, pc_write, pc_rst, ir_load,
                  alu_op, mem_req, dm_we, halted, timeout, ill_op};

    int n_vec = 0;
    int n_err = 0;

    function automatic outs_t idle(input logic [2:0] st);
        outs_t o;
        o = '0;
        o.state  = st;
        o.alu_op = 2'b10;
        return o;
    endfunction

    function automatic outs_t fetch_e();
        outs_t o;
        o = idle(3'd2);
        o.ir_load  = 1'b1;
        o.pc_write = 1'b1;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_to_fetch();
        rst_f = 1'b1;
        mem_ready = 1'b0;
        tick();
        rst_f = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        outs_t q[$];
        outs_t e;
        opcode = 4'd0;
        rst_f = 1'b1;
        tick();
        tick();
        rst_f = 1'b0;
        q.push_back(idle(3'd0));
        e = idle(3'd1); e.pc_rst = 1'b1; q.push_back(e);
        q.push_back(fetch_e());
        for (int i = 0; i < q.size(); i++) begin
            #1;
            n_vec++;
            if (obs !== q[i]) begin
                $display("FAIL reset step %0d: got %h expected %h", i, obs, q[i]);
                n_err++;
            end
            if (i < q.size() - 1) tick();
        end
    endtask

    task automatic test_alu(input logic [3:0] mm_v, input logic [1:0] aop);
        outs_t q[$];
        outs_t e;
        start_to_fetch();
        opcode = 4'd8;
        mm = mm_v;
        stat = 4'd0;
        q.push_back(fetch_e());
        q.push_back(idle(3'd3));
        e = idle(3'd4); e.alu_op = aop; q.push_back(e);
        e = idle(3'd5); e.alu_op = aop; q.push_back(e);
        e = idle(3'd6); e.alu_op = aop; e.rf_we = 1'b1; e.rb_sel = 1'b1; q.push_back(e);
        q.push_back(fetch_e());
        for (int i = 0; i < q.size(); i++) begin
            #1;
            n_vec++;
            if (obs !== q[i]) begin
                $display("FAIL alu mm=%0d step %0d: got %h expected %h", mm_v, i, obs, q[i]);
                n_err++;
            end
            if (i < q.size() - 1) tick();
        end
    endtask

    task automatic test_branch(input logic [3:0] op, input logic [3:0] mm_v,
                               input logic [3:0] st_v, input logic abs_v, input logic taken);
        outs_t q[$];
        outs_t e;
        start_to_fetch();
        opcode = op;
        mm = mm_v;
        stat = st_v;
        q.push_back(fetch_e());
        e = idle(3'd3);
        e.br_sel = abs_v;
        e.pc_sel = taken;
        e.pc_write = taken;
        q.push_back(e);
        q.push_back(fetch_e());
        for (int i = 0; i < q.size(); i++) begin
            #1;
            n_vec++;
            if (obs !== q[i]) begin
                $display("FAIL branch op=%0d step %0d: got %h expected %h", op, i, obs, q[i]);
                n_err++;
            end
            if (i < q.size() - 1) tick();
        end
    endtask

    // LOD with mem_ready low for three MEM cycles, high on the fourth
    task automatic test_lod_wait();
        outs_t q[$];
        outs_t e;
        start_to_fetch();
        opcode = 4'd1;
        mm = 4'd3;
        q.push_back(fetch_e());
        q.push_back(idle(3'd3));
        e = idle(3'd4); e.alu_op = 2'b01; q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            e = idle(3'd5); e.alu_op = 2'b01; e.mem_req = 1'b1; q.push_back(e);
        end
        e = idle(3'd6); e.rf_we = 1'b1; e.wb_sel = 2'd1; q.push_back(e);
        q.push_back(fetch_e());
        for (int i = 0; i < q.size(); i++) begin
            mem_ready = (i == 6);
            #1;
            n_vec++;
            if (obs !== q[i]) begin
                $display("FAIL lod_wait step %0d: got %h expected %h", i, obs, q[i]);
                n_err++;
            end
            if (i < q.size() - 1) tick();
        end
        mem_ready = 1'b0;
    endtask

    // STR that never completes: 16 MEM cycles, then HALT with sticky timeout, cleared by reset
    task automatic test_str_timeout();
        outs_t q[$];
        outs_t e;
        start_to_fetch();
        opcode = 4'd2;
        mm = 4'd0;
        q.push_back(fetch_e());
        q.push_back(idle(3'd3));
        e = idle(3'd4); e.alu_op = 2'b01; q.push_back(e);
        for (int k = 0; k < 16; k++) begin
            e = idle(3'd5); e.alu_op = 2'b01; e.mem_req = 1'b1; e.dm_we = 1'b1; q.push_back(e);
        end
        e = idle(3'd7); e.halted = 1'b1; e.timeout = 1'b1; q.push_back(e);
        q.push_back(e);
        for (int i = 0; i < q.size(); i++) begin
            mem_ready = 1'b0;
            #1;
            n_vec++;
            if (obs !== q[i]) begin
                $display("FAIL str_timeout step %0d: got %h expected %h", i, obs, q[i]);
                n_err++;
            end
            if (i < q.size() - 1) tick();
        end
        rst_f = 1'b1;
        tick();
        #1;
        n_vec++;
        if (obs !== idle(3'd0)) begin
            $display("FAIL halt_reset: got %h expected %h", obs, idle(3'd0));
            n_err++;
        end
        rst_f = 1'b0;
    endtask

    // mem_ready arriving on the last allowed MEM cycle completes the store, no timeout
    task automatic test_str_boundary();
        outs_t q[$];
        outs_t e;
        start_to_fetch();
        opcode = 4'd2;
        q.push_back(fetch_e());
        q.push_back(idle(3'd3));
        e = idle(3'd4); e.alu_op = 2'b01; q.push_back(e);
        for (int k = 0; k < 16; k++) begin
            e = idle(3'd5); e.alu_op = 2'b01; e.mem_req = 1'b1; e.dm_we = 1'b1; q.push_back(e);
        end
        q.push_back(fetch_e());
        for (int i = 0; i < q.size(); i++) begin
            mem_ready = (i == 18);
            #1;
            n_vec++;
            if (obs !== q[i]) begin
                $display("FAIL str_boundary step %0d: got %h expected %h", i, obs, q[i]);
                n_err++;
            end
            if (i < q.size() - 1) tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_swp();
        outs_t q[$];
        outs_t e;
        start_to_fetch();
        opcode = 4'd3;
        mm = 4'd8;
        q.push_back(fetch_e());
        q.push_back(idle(3'd3));
        q.push_back(idle(3'd4));
        e = idle(3'd5); e.rf_we = 1'b1; e.wb_sel = 2'd2; e.rb_sel = 1'b1; q.push_back(e);
        e = idle(3'd6); e.rf_we = 1'b1; e.wb_sel = 2'd3; e.rb_sel = 1'b1; q.push_back(e);
        q.push_back(fetch_e());
        for (int i = 0; i < q.size(); i++) begin
            #1;
            n_vec++;
            if (obs !== q[i]) begin
                $display("FAIL swp step %0d: got %h expected %h", i, obs, q[i]);
                n_err++;
            end
            if (i < q.size() - 1) tick();
        end
    endtask

    task automatic test_halt_illegal();
        outs_t q[$];
        outs_t e;
        start_to_fetch();
        opcode = 4'd9;
        q.push_back(fetch_e());
        e = idle(3'd3); e.ill_op = 1'b1; q.push_back(e);
        q.push_back(fetch_e());
        q.push_back(idle(3'd3));
        e = idle(3'd7); e.halted = 1'b1; q.push_back(e);
        q.push_back(e);
        for (int i = 0; i < q.size(); i++) begin
            if (i == 2) opcode = 4'd15;
            #1;
            n_vec++;
            if (obs !== q[i]) begin
                $display("FAIL halt_illegal step %0d: got %h expected %h", i, obs, q[i]);
                n_err++;
            end
            if (i < q.size() - 1) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu(4'd8, 2'b01);
        test_alu(4'd0, 2'b00);
        test_branch(4'd6, 4'b0010, 4'b0001, 1'b1, 1'b1);
        test_branch(4'd5, 4'b0010, 4'b0001, 1'b0, 1'b0);
        test_branch(4'd4, 4'b0011, 4'b0001, 1'b1, 1'b1);
        test_branch(4'd7, 4'b0011, 4'b0001, 1'b0, 1'b0);
        test_lod_wait();
        test_str_timeout();
        test_str_boundary();
        test_swp();
        test_halt_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_mc.md
Name: ctrl_mc

Overview:
- Parametrised multi-cycle control FSM for the SISC processor. It is the successor to the fixed 7-state controller.
- Added behaviour over the previous controller:
  - HALT state in hardware instead of a simulation stop.
  - Short path for branches and NOOP.
  - LOD/STR/SWP sequencing.
  - Data-memory ready handshake with a timeout.
  - Illegal-opcode flag.
- Sits between the IR/status register and the datapath muxes, register file, PC and data memory.

Parameters:
OP_W, 4, opcode field width
MM_W, 4, mm field and stat width
IMM_MM, 8, mm value selecting immediate ALU operand
MAX_WAIT, 15, max MEM-state cycles with mem_ready low before timeout (1..255)
WAIT_W, 8, wait counter width (2^WAIT_W > MAX_WAIT)

Ports:
clk  in  1  clock, all state changes on rising edge
rst_f  in  1  synchronous reset, active-high (asserted = 1)
opcode  in  OP_W  opcode from IR, stable DECODE through WRITEBACK
mm  in  MM_W  mm field from IR
stat  in  MM_W  status flags
mem_ready  in  1  data memory completes access this cycle
rf_we  out  1  register file write enable
wb_sel  out  2  write data: 0 ALU, 1 memory, 2 operand-B, 3 operand-A
rb_sel  out  1  read port B selects rd field
br_sel  out  1  1 absolute branch address, 0 PC-relative
pc_sel  out  1  1 branch address, 0 PC+1
pc_write  out  1  PC load enable
pc_rst  out  1  PC clear
ir_load  out  1  IR load enable
alu_op  out  2  00 reg ALU, 01 immediate/address add, 10 pass-through
mem_req  out  1  data memory request
dm_we  out  1  data memory write
halted  out  1  in HALT state
timeout  out  1  sticky, set on mem wait timeout
ill_op  out  1  one-cycle pulse in DECODE on unknown opcode
state  out  3  present state code

Behaviour:
- Opcodes: NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU=8, HLT=15. All others are illegal.
- State codes: START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7.
- Reset (rst_f=1 at an edge, including mid-instruction or during HALT):
  - state to START0, wait counter to 0, timeout to 0.
- Output defaults in every state unless overridden below: all 0 except alu_op=10.
- Outputs are decoded combinationally from present state plus opcode/mm/stat/mem_ready.
- START0 -> START1.
- START1: pc_rst=1. Next FETCH.
- FETCH: ir_load=1, pc_write=1, pc_sel=0. Next DECODE.
- DECODE:
  - HLT -> HALT.
  - NOOP -> FETCH.
  - Illegal opcode -> ill_op=1, next FETCH.
  - Branches: br_sel=1 for BRA/BNE, 0 for BRR/BNR.
    - BRA/BRR taken iff (stat & mm) != 0.
    - BNE/BNR taken iff (stat & mm) == 0.
    - Taken: pc_sel=1, pc_write=1.
    - Taken or not, next state is FETCH.
  - All others -> EXECUTE.
- EXECUTE:
  - ALU: alu_op=01 if mm==IMM_MM, else 00.
  - LOD/STR: alu_op=01.
  - SWP: alu_op=10.
  - Next MEM.
- MEM:
  - ALU: alu_op as in EXECUTE; next WRITEBACK.
  - LOD: mem_req=1, alu_op=01.
  - STR: mem_req=1, dm_we=1, alu_op=01.
  - LOD/STR wait handling:
    - mem_ready=1: clear counter; next WRITEBACK for LOD, FETCH for STR.
    - mem_ready=0 and counter < MAX_WAIT: increment counter, stay in MEM.
    - Counter == MAX_WAIT with mem_ready=0: set timeout, clear counter, next HALT.
    - mem_ready=1 on the same cycle the counter reaches MAX_WAIT: counts as completion, no timeout.
  - SWP: rf_we=1, wb_sel=2, rb_sel=1; next WRITEBACK.
- WRITEBACK:
  - ALU: rf_we=1, wb_sel=0, rb_sel=1, alu_op as in EXECUTE.
  - LOD: rf_we=1, wb_sel=1.
  - SWP: rf_we=1, wb_sel=3, rb_sel=1.
  - Next FETCH.
- HALT: halted=1, all strobes 0, self-loop. Only reset exits.
- Counter width: it never exceeds MAX_WAIT; there is no wrap.

Test Plan:
- Reset sequence: rst_f=1 for 2 cycles, then 0 -> state 0,1,2; pc_rst=1 only in START1; ir_load=1 and pc_write=1 only in FETCH.
- ALU immediate: opcode=8, mm=8 -> states 2,3,4,5,6,2; alu_op=01 in EXECUTE/MEM/WB; rf_we=1 only in WB. Repeat with mm=0 -> alu_op=00.
- Branches:
  - BNE, mm=4'b0010, stat=4'b0001 -> pc_sel=1, pc_write=1, br_sel=1 in DECODE, next FETCH.
  - BRR, mm=4'b0010, stat=4'b0001 -> pc_write=0, br_sel=0, next FETCH.
- LOD with mem_ready low 3 cycles: MEM held 4 cycles with mem_req=1; then WB with wb_sel=1, rf_we=1.
- STR with mem_ready held 0, MAX_WAIT=15 -> 16 MEM cycles, then HALT with timeout=1 and halted=1. rst_f=1 -> START0, timeout=0.
- HLT (opcode=15) -> HALT after DECODE, outputs idle. Opcode=9 -> ill_op pulses one cycle in DECODE, next FETCH.
